simon_core_n: RTL and testbench

- Parametrised, self-contained Simon game engine for the 250 ms-tick lab platform.
- Supports N channels, configurable show and response timing, a maximum sequence length, and a retained best score.
- Replaces the fixed 4-switch datapath plus separate state machine with one block.
- The board top feeds it switches and seed, and drives the HEX/LED decoders from its outputs.

---
 rtl/simon_core_n.sv | 183 ++++++++++++++++++
 tb/tb_simon_core_n.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simon_core_n.sv
// Simon game engine: LFSR-driven light sequence, timed show/response phases,
// N switch/LED channels and a best-score register retained across games.
module simon_core_n #(
  parameter int          NCH        = 4,
  parameter int          SCORE_W    = 8,
  parameter int          MAX_LEN    = 99,
  parameter int          ON_TICKS   = 4,
  parameter int          OFF_TICKS  = 2,
  parameter int          USER_TICKS = 20,
  parameter logic [7:0]  TAPS       = 8'hB8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [NCH-1:0]     sw,
  input  logic [7:0]         seed,
  output logic [NCH-1:0]     led,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] seq_idx,
  output logic [SCORE_W-1:0] best,
  output logic               simons_turn,
  output logic               fail,
  output logic               win,
  output logic               new_best
);

  localparam int CH_W  = $clog2(NCH);
  localparam int T_SH  = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int T_MAX = (T_SH > USER_TICKS) ? T_SH : USER_TICKS;
  localparam int TIM_W = $clog2(T_MAX + 1);

  localparam logic [TIM_W-1:0]   ON_LAST   = TIM_W'(ON_TICKS - 1);
  localparam logic [TIM_W-1:0]   OFF_LAST  = TIM_W'(OFF_TICKS - 1);
  localparam logic [TIM_W-1:0]   USER_LOAD = TIM_W'(USER_TICKS);
  localparam logic [TIM_W-1:0]   T_ONE     = TIM_W'(1);
  localparam logic [SCORE_W-1:0] S_ONE     = SCORE_W'(1);
  localparam logic [SCORE_W-1:0] S_MAX     = SCORE_W'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE, S_SHOW_ON, S_SHOW_OFF, S_USER_WAIT,
    S_USER_HOLD, S_ADVANCE, S_FAIL, S_WIN
  } state_t;

  state_t             r_state;
  logic [7:0]         r_lfsr;
  logic [TIM_W-1:0]   r_timer;
  logic [SCORE_W-1:0] r_score;
  logic [SCORE_W-1:0] r_idx;
  logic [SCORE_W-1:0] r_best;
  logic               r_nb;
  logic               r_win_ph;

  logic [7:0]         w_seed_eff;
  logic [7:0]         w_lfsr_nxt;
  logic [NCH-1:0]     w_exp;
  logic [NCH-1:0]     w_alt;
  logic [SCORE_W-1:0] w_idx_nxt;
  logic               w_wrong;

  assign w_seed_eff = seed | 8'h01;
  assign w_lfsr_nxt = {r_lfsr[6:0], ^(r_lfsr & TAPS)};
  assign w_exp      = NCH'(1) << r_lfsr[CH_W-1:0];
  assign w_idx_nxt  = r_idx + S_ONE;
  assign w_wrong    = (sw != '0) && (sw != w_exp);

  // Even-numbered channels lit: the first WIN frame (bit0 set).
  always_comb begin
    w_alt = '0;
    for (int i = 0; i < NCH; i += 2) w_alt[i] = 1'b1;
  end

  always_comb begin
    led = '0;
    case (r_state)
      S_SHOW_ON, S_USER_HOLD: led = w_exp;
      S_FAIL:                 led = '1;
      S_WIN:                  led = r_win_ph ? ~w_alt : w_alt;
      default:                led = '0;
    endcase
  end

  assign score       = r_score;
  assign seq_idx     = r_idx;
  assign best        = r_best;
  assign simons_turn = (r_state == S_SHOW_ON) || (r_state == S_SHOW_OFF);
  assign fail        = (r_state == S_FAIL);
  assign win         = (r_state == S_WIN);
  assign new_best    = r_nb && ((r_state == S_FAIL) || (r_state == S_WIN));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_lfsr   <= 8'h01;
      r_timer  <= '0;
      r_score  <= '0;
      r_idx    <= '0;
      r_best   <= '0;
      r_nb     <= 1'b0;
      r_win_ph <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_FAIL, S_WIN: begin
          if (start) begin
            r_score  <= S_ONE;
            r_lfsr   <= w_seed_eff;
            r_idx    <= '0;
            r_timer  <= '0;
            r_nb     <= 1'b0;
            r_win_ph <= 1'b0;
            r_state  <= S_SHOW_ON;
          end else if (r_state == S_WIN) begin
            r_win_ph <= ~r_win_ph;
          end
        end
        S_SHOW_ON: begin
          if (r_timer == ON_LAST) begin
            r_timer <= '0;
            r_lfsr  <= w_lfsr_nxt;
            r_idx   <= w_idx_nxt;
            r_state <= S_SHOW_OFF;
          end else begin
            r_timer <= r_timer + T_ONE;
          end
        end
        S_SHOW_OFF: begin
          if (r_timer == OFF_LAST) begin
            r_timer <= '0;
            if (r_idx == r_score) begin
              // Replay the sequence from the seed for the user to echo.
              r_lfsr  <= w_seed_eff;
              r_idx   <= '0;
              r_timer <= USER_LOAD;
              r_state <= S_USER_WAIT;
            end else begin
              r_state <= S_SHOW_ON;
            end
          end else begin
            r_timer <= r_timer + T_ONE;
          end
        end
        S_USER_WAIT: begin
          r_timer <= r_timer - T_ONE;
          // A press on the last allowed cycle wins over the timeout.
          if (sw == w_exp)          r_state <= S_USER_HOLD;
          else if (w_wrong)         r_state <= S_FAIL;
          else if (r_timer == T_ONE) r_state <= S_FAIL;
        end
        S_USER_HOLD: begin
          if (sw == '0) begin
            r_lfsr <= w_lfsr_nxt;
            r_idx  <= w_idx_nxt;
            if (w_idx_nxt == r_score) begin
              r_state <= S_ADVANCE;
            end else begin
              r_timer <= USER_LOAD;
              r_state <= S_USER_WAIT;
            end
          end else if (sw != w_exp) begin
            r_state <= S_FAIL;
          end
        end
        S_ADVANCE: begin
          if (r_score > r_best) begin
            r_best <= r_score;
            r_nb   <= 1'b1;
          end
          if (r_score == S_MAX) begin
            r_win_ph <= 1'b0;
            r_state  <= S_WIN;
          end else begin
            r_score <= r_score + S_ONE;
            r_lfsr  <= w_seed_eff;
            r_idx   <= '0;
            r_timer <= '0;
            r_state <= S_SHOW_ON;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_simon_core_n.sv
// Bench for simon_core_n: directed plan scenarios plus randomized games,
// checked against a sequence model derived from the seed.
module tb_simon_core_n;

  localparam int NCH = 4;
  localparam int ML  = 2;
  localparam int ON  = 4;
  localparam int OFF = 2;
  localparam int UT  = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] sw = 4'h0;
  logic [7:0] seed = 8'h00;
  logic [3:0] led;
  logic [7:0] score, seq_idx, best;
  logic       simons_turn, fail, win, new_best;

  int total = 0;
  int bad   = 0;
  int m_best = 0;
  bit m_nb   = 1'b0;

  simon_core_n #(
    .NCH(NCH), .SCORE_W(8), .MAX_LEN(ML), .ON_TICKS(ON),
    .OFF_TICKS(OFF), .USER_TICKS(UT), .TAPS(8'hB8)
  ) u_dut (
    .clk(clk), .rst(rst), .start(start), .sw(sw), .seed(seed),
    .led(led), .score(score), .seq_idx(seq_idx), .best(best),
    .simons_turn(simons_turn), .fail(fail), .win(win), .new_best(new_best)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // k-th light of the game started with seed sd.
  function automatic logic [3:0] chan(input logic [7:0] sd, input int k);
    logic [7:0] l;
    l = sd | 8'h01;
    for (int i = 0; i < k; i++) l = {l[6:0], ^(l & 8'hB8)};
    return 4'b0001 << l[1:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_led"},   32'(led), 32'h0);
    chk({tag, "_score"}, 32'(score), 32'h0);
    chk({tag, "_idx"},   32'(seq_idx), 32'h0);
    chk({tag, "_best"},  32'(best), 32'h0);
    chk({tag, "_flags"}, 32'({simons_turn, fail, win, new_best}), 32'h0);
  endtask

  task automatic begin_game(input logic [7:0] sd);
    seed  = sd;
    start = 1'b1;
    tick;
    start = 1'b0;
    m_nb  = 1'b0;
    chk("start_score", 32'(score), 32'h1);
    chk("start_idx", 32'(seq_idx), 32'h0);
  endtask

  // Checks the whole Simon display for a game of length s; ends in USER_WAIT.
  task automatic show(input int s, input bit noise);
    for (int k = 0; k < s; k++) begin
      for (int c = 0; c < ON; c++) begin
        chk("show_on_led", 32'(led), 32'(chan(seed, k)));
        chk("show_on_turn", 32'(simons_turn), 32'h1);
        chk("show_on_idx", 32'(seq_idx), 32'(k));
        if (noise) begin
          sw    = 4'($urandom);
          start = 1'($urandom);
        end
        tick;
      end
      sw    = 4'h0;
      start = 1'b0;
      for (int c = 0; c < OFF; c++) begin
        chk("show_off_led", 32'(led), 32'h0);
        chk("show_off_turn", 32'(simons_turn), 32'h1);
        tick;
      end
    end
    chk("wait_turn", 32'(simons_turn), 32'h0);
    chk("wait_led", 32'(led), 32'h0);
    chk("wait_score", 32'(score), 32'(s));
    chk("wait_idx", 32'(seq_idx), 32'h0);
  endtask

  task automatic press(input int k, input int wt, input int hd);
    logic [3:0] e;
    e = chan(seed, k);
    for (int i = 0; i < wt; i++) begin
      chk("idle_fail", 32'(fail), 32'h0);
      tick;
    end
    sw = e;
    tick;
    chk("hold_led", 32'(led), 32'(e));
    chk("hold_idx", 32'(seq_idx), 32'(k));
    for (int i = 1; i < hd; i++) begin
      tick;
      chk("hold_led2", 32'(led), 32'(e));
    end
    sw = 4'h0;
    tick;
  endtask

  // Called in the ADVANCE cycle of a round of length s.
  task automatic advance_chk(input int s);
    chk("adv_led", 32'(led), 32'h0);
    chk("adv_idx", 32'(seq_idx), 32'(s));
    chk("adv_score", 32'(score), 32'(s));
    if (s > m_best) begin
      m_best = s;
      m_nb   = 1'b1;
    end
    tick;
    chk("adv_best", 32'(best), 32'(m_best));
    if (s == ML) begin
      chk("win_flag", 32'(win), 32'h1);
      chk("win_led0", 32'(led), 32'h5);
      chk("win_score", 32'(score), 32'(ML));
      chk("win_nb", 32'(new_best), 32'(m_nb));
    end else begin
      chk("next_score", 32'(score), 32'(s + 1));
      chk("next_turn", 32'(simons_turn), 32'h1);
    end
  endtask

  task automatic round(input int s);
    show(s, 1'($urandom_range(0, 1)));
    for (int k = 0; k < s; k++) press(k, $urandom_range(0, 5), $urandom_range(1, 3));
    advance_chk(s);
  endtask

  task automatic play_rand(input logic [7:0] sd);
    int fr, fp, kind;
    logic [3:0] e, w;
    begin_game(sd);
    fr = $urandom_range(1, ML + 1);
    for (int s = 1; s <= ML; s++) begin
      if (s != fr) begin
        round(s);
      end else begin
        show(s, 1'b1);
        fp = $urandom_range(0, s - 1);
        for (int k = 0; k < fp; k++) press(k, $urandom_range(0, 4), $urandom_range(1, 2));
        e = chan(seed, fp);
        w = {e[2:0], e[3]};
        kind = $urandom_range(0, 3);
        case (kind)
          0: sw = w;
          1: sw = e | w;
          2: begin
            sw = e;
            tick;
            chk("rf_hold_led", 32'(led), 32'(e));
            sw = w;
          end
          default: for (int i = 0; i < UT - 1; i++) tick;
        endcase
        tick;
        sw = 4'h0;
        chk("rf_fail", 32'(fail), 32'h1);
        chk("rf_led", 32'(led), 32'hF);
        chk("rf_score", 32'(score), 32'(s));
        chk("rf_idx", 32'(seq_idx), 32'(fp));
        chk("rf_nb", 32'(new_best), 32'(m_nb));
        chk("rf_best", 32'(best), 32'(m_best));
        return;
      end
    end
  endtask

  initial begin
    // Reset state.
    rst = 1'b1;
    repeat (3) tick;
    chk_reset("rst0");
    rst = 1'b0;
    tick;
    chk_reset("idle");

    // Game 1, seed 0: first light is channel 1, win at length 2.
    begin_game(8'h00);
    chk("g1_first_led", 32'(led), 32'h2);
    show(1, 1'b0);
    press(0, 0, 1);
    advance_chk(1);
    chk("g1_best1", 32'(best), 32'h1);
    chk("g1_r2_led", 32'(led), 32'h2);
    show(2, 1'b0);
    press(0, 1, 2);
    press(1, 0, 1);
    advance_chk(2);
    tick;
    chk("win_led1", 32'(led), 32'hA);
    chk("win_hold", 32'(win), 32'h1);
    tick;
    chk("win_led2", 32'(led), 32'h5);
    chk("win_noswap", 32'(score), 32'h2);

    // Restart from WIN keeps best, clears new_best; multi-bit press fails.
    begin_game(8'h00);
    chk("rs_best", 32'(best), 32'h2);
    chk("rs_turn", 32'(simons_turn), 32'h1);
    show(1, 1'b0);
    sw = 4'b0011;
    tick;
    sw = 4'h0;
    chk("mb_fail", 32'(fail), 32'h1);
    chk("mb_led", 32'(led), 32'hF);
    chk("mb_score", 32'(score), 32'h1);
    chk("mb_nb", 32'(new_best), 32'h0);
    tick;
    chk("mb_hold", 32'(fail), 32'h1);

    // Timeout after exactly UT idle cycles.
    begin_game(8'($urandom));
    show(1, 1'b1);
    for (int i = 0; i < UT - 1; i++) begin
      chk("to_early", 32'(fail), 32'h0);
      tick;
    end
    chk("to_last", 32'(fail), 32'h0);
    tick;
    chk("to_fail", 32'(fail), 32'h1);
    chk("to_led", 32'(led), 32'hF);

    // Press on the final cycle beats the timeout; then reset mid-hold.
    begin_game(8'($urandom));
    show(1, 1'b0);
    for (int i = 0; i < UT - 1; i++) tick;
    sw = chan(seed, 0);
    tick;
    chk("late_led", 32'(led), 32'(chan(seed, 0)));
    chk("late_fail", 32'(fail), 32'h0);
    sw = 4'h0;
    tick;
    advance_chk(1);
    show(2, 1'b0);
    sw = chan(seed, 0);
    tick;
    chk("pre_rst_led", 32'(led), 32'(chan(seed, 0)));
    rst = 1'b1;
    sw  = 4'h0;
    tick;
    chk_reset("midrst");
    rst = 1'b0;
    m_best = 0;
    m_nb   = 1'b0;
    tick;

    // Randomized games.
    for (int g = 0; g < 10; g++) play_rand(8'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
